// File: rtl/mux6_arb_if.sv
// Channel bundle between six requesters and the round-robin arbiter.
// With MUX6_ARB_LOCK_EN defined, the bundle also carries the lock input.
interface mux6_arb_if;
   logic [5:0] req;
   logic [5:0] a;
   logic [2:0] sel;
   logic [5:0] grant;
   logic       valid;
   logic       out;
`ifdef MUX6_ARB_LOCK_EN
   logic       lock;
`endif

   // The requester side drives req/a and observes the grant.
   modport master (
      output req, a,
`ifdef MUX6_ARB_LOCK_EN
      output lock,
`endif
      input  sel, grant, valid, out
   );

   // The arbiter side observes the requests and drives the grant.
   modport slave (
      input  req, a,
`ifdef MUX6_ARB_LOCK_EN
      input  lock,
`endif
      output sel, grant, valid, out
   );
endinterface

// File: rtl/mux6_rr_arbiter.sv
// Round-robin arbiter sequencing a 6:1 single-bit channel with bounded time slots.
// Optional MUX6_ARB_LOCK_EN: the owner may hold the channel past its slot while lock=1.
module mux6_rr_arbiter #(
   parameter int unsigned SLOT_LEN = 4
) (
   input  logic       clk,
   input  logic       rst,
   mux6_arb_if.slave  bus
);

   typedef enum logic {IDLE, GRANT} state_e;

   localparam logic [2:0] CNT_MAX = 3'(SLOT_LEN - 1);

   function automatic logic [2:0] inc6(input logic [2:0] i);
      return (i >= 3'd5) ? 3'd0 : i + 3'd1;
   endfunction

   // First requesting index found scanning start, start+1, ... with 5 wrapping to 0.
   function automatic logic [2:0] winner(input logic [5:0] r, input logic [2:0] start);
      logic [2:0] idx;
      logic [2:0] w;
      logic       found;
      idx   = start;
      w     = start;
      found = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (!found && r[idx]) begin
            w     = idx;
            found = 1'b1;
         end
         idx = inc6(idx);
      end
      return w;
   endfunction

   state_e     state_q, state_d;
   logic [2:0] sel_q, sel_d;
   logic [5:0] grant_q, grant_d;
   logic       valid_q, valid_d;
   logic [2:0] cnt_q, cnt_d;
   logic [2:0] ptr_q, ptr_d;

   logic [2:0] win_idle;
   logic [2:0] win_next;
   logic       timeout;
   logic       release_slot;
   logic       mux_bit;

   assign win_idle = winner(bus.req, ptr_q);
   assign win_next = winner(bus.req, inc6(sel_q));

`ifdef MUX6_ARB_LOCK_EN
   assign timeout = (cnt_q == CNT_MAX) && !bus.lock;
`else
   assign timeout = (cnt_q == CNT_MAX);
`endif

   assign release_slot = !bus.req[sel_q] || timeout;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= 3'd0;
         grant_q <= 6'd0;
         valid_q <= 1'b0;
         cnt_q   <= 3'd0;
         ptr_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
      end
   end

   // NOTE: every next-state signal gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      grant_d = grant_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (|bus.req) begin
               state_d = GRANT;
               sel_d   = win_idle;
               grant_d = 6'b000001 << win_idle;
               valid_d = 1'b1;
               cnt_d   = 3'd0;
            end
         end
         GRANT: begin
            if (!release_slot) begin
               // Saturate so a locked owner releases on the first unlocked cycle.
               cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 3'd1;
            end else if (|bus.req) begin
               sel_d   = win_next;
               grant_d = 6'b000001 << win_next;
               cnt_d   = 3'd0;
               ptr_d   = inc6(win_next);
            end else begin
               state_d = IDLE;
               grant_d = 6'd0;
               valid_d = 1'b0;
               ptr_d   = inc6(sel_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Indices 6 and 7 are unreachable but still decode to 0.
   always_comb begin
      mux_bit = 1'b0;
      case (sel_q)
         3'd0:    mux_bit = bus.a[0];
         3'd1:    mux_bit = bus.a[1];
         3'd2:    mux_bit = bus.a[2];
         3'd3:    mux_bit = bus.a[3];
         3'd4:    mux_bit = bus.a[4];
         3'd5:    mux_bit = bus.a[5];
         default: mux_bit = 1'b0;
      endcase
   end

   assign bus.sel   = sel_q;
   assign bus.grant = grant_q;
   assign bus.valid = valid_q;
   assign bus.out   = valid_q & mux_bit;

endmodule

// File: tb/tb_mux6_rr_arbiter.sv
// Directed bench for mux6_rr_arbiter with SLOT_LEN=4; expected values are hand-derived.
// The lock section is built only when MUX6_ARB_LOCK_EN is defined.
module tb_mux6_rr_arbiter;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   mux6_arb_if bus ();

   mux6_rr_arbiter #(.SLOT_LEN(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [2:0] s, input logic [5:0] g,
                            input logic v, input logic o);
      check({tag, ".sel"},   8'(bus.sel),   8'(s));
      check({tag, ".grant"}, 8'(bus.grant), 8'(g));
      check({tag, ".valid"}, 8'(bus.valid), 8'(v));
      check({tag, ".out"},   8'(bus.out),   8'(o));
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      rst     = 1'b1;
      bus.req = 6'b111111;
      bus.a   = 6'b111111;
`ifdef MUX6_ARB_LOCK_EN
      bus.lock = 1'b0;
`endif

      // Reset held two cycles with everyone requesting.
      step();
      step();
      check_all("reset", 3'd0, 6'b000000, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      check_all("post_reset", 3'd0, 6'b000001, 1'b1, 1'b1);

      // Back to idle with a clean pointer.
      rst     = 1'b1;
      bus.req = 6'b000000;
      step();
      rst = 1'b0;

      // Sole requester 2 for 10 cycles; a[2] toggles, other bits opposite.
      bus.req = 6'b000100;
      for (int i = 0; i < 10; i++) begin
         bus.a = (i % 2 == 1) ? 6'b000100 : 6'b111011;
         step();
         check("single.sel",   8'(bus.sel),   8'd2);
         check("single.grant", 8'(bus.grant), 8'b000100);
         check("single.valid", 8'(bus.valid), 8'd1);
         check("single.out",   8'(bus.out),   8'((i % 2 == 1) ? 1 : 0));
      end

      // Owner drops with nobody else requesting: idle, sel held, out gated.
      bus.req = 6'b000000;
      bus.a   = 6'b111111;
      step();
      check_all("single_idle", 3'd2, 6'b000000, 1'b0, 1'b0);

      // Rotation between 0 and 5 from a reset pointer, wrap 5 -> 0.
      rst     = 1'b1;
      bus.req = 6'b100001;
      bus.a   = 6'b100000;
      step();
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         check("rot.sel",   8'(bus.sel),   8'(((k / 4) % 2 == 1) ? 5 : 0));
         check("rot.valid", 8'(bus.valid), 8'd1);
         check("rot.out",   8'(bus.out),   8'(((k / 4) % 2 == 1) ? 1 : 0));
      end

      // Owner 0 drops, requester 3 wins the scan from 1.
      bus.req = 6'b001000;
      bus.a   = 6'b001000;
      step();
      check_all("drop.grant3", 3'd3, 6'b001000, 1'b1, 1'b1);
      step();
      check_all("drop.hold3", 3'd3, 6'b001000, 1'b1, 1'b1);
      bus.req = 6'b000000;
      step();
      check_all("drop.idle", 3'd3, 6'b000000, 1'b0, 1'b0);
      bus.req = 6'b010000;
      bus.a   = 6'b000000;
      step();
      check_all("drop.grant4", 3'd4, 6'b010000, 1'b1, 1'b0);

      // Move to owner 5, then reset mid-grant.
      bus.req = 6'b100000;
      bus.a   = 6'b100000;
      step();
      check_all("mid.own5", 3'd5, 6'b100000, 1'b1, 1'b1);
      rst     = 1'b1;
      bus.req = 6'b111111;
      bus.a   = 6'b111110;
      step();
      check_all("mid.reset", 3'd0, 6'b000000, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      check_all("mid.restart", 3'd0, 6'b000001, 1'b1, 1'b0);

`ifdef MUX6_ARB_LOCK_EN
      begin
         bit handed;
         rst     = 1'b1;
         bus.req = 6'b000000;
         step();
         rst     = 1'b0;
         bus.req = 6'b000010;
         step();
         check("lock.own1", 8'(bus.sel), 8'd1);
         bus.req  = 6'b000011;
         bus.lock = 1'b1;
         for (int i = 0; i < 12; i++) begin
            step();
            check("lock.hold.sel",   8'(bus.sel),   8'd1);
            check("lock.hold.grant", 8'(bus.grant), 8'b000010);
         end
         bus.lock = 1'b0;
         handed   = 1'b0;
         for (int i = 0; i < 4; i++) begin
            step();
            if (!handed && bus.sel == 3'd0 && bus.grant == 6'b000001) handed = 1'b1;
         end
         check("lock.handover", 8'(handed), 8'd1);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mux6_rr_arbiter.md
Name: mux6_rr_arbiter

Overview:
- Round-robin arbiter sharing one 6:1 single-bit selection channel among six requesters.
- Each requester i drives req[i] and its data bit a[i].
- The block grants one requester at a time for a bounded time slot.
- It drives the channel select sel and a one-hot grant, and presents the selected data bit on out.
- It sits in front of the workshop 6:1 mux datapath as its sequencer.

Parameters:
SLOT_LEN, 4, maximum consecutive cycles a single grant is held; legal range 1..8; internal slot counter is 3 bits

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
req  input  6  request vector, req[i]=1 means requester i wants the channel
a  input  6  data bits, a[i] belongs to requester i
sel  output  3  registered index of current owner, 0..5 only
grant  output  6  registered one-hot grant, all-zero when idle
valid  output  1  registered, 1 while a grant is active
out  output  1  combinational a[sel] when valid=1, else 0

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at an edge, overrides everything):
  - state=IDLE, sel=0, grant=0, valid=0, slot counter cnt=0, rotation pointer ptr=0.
  - out reads 0 during and after reset until the next grant.
- Winner function W(start):
  - Returns the first index j with req[j]=1, scanning start, start+1, … modulo 6.
  - Defined only when req≠0.
- State IDLE:
  - If req≠0: next edge goes to GRANT with sel=W(ptr), grant=onehot(sel), valid=1, cnt=0.
  - Otherwise remain IDLE with outputs unchanged.
- Latency: req asserted in cycle t in IDLE gives valid=1 in cycle t+1.
- State GRANT, evaluated each cycle:
  - release = (req[sel]==0) OR (cnt==SLOT_LEN-1).
  - No release: cnt<=cnt+1, sel and grant held.
  - Release with req≠0: back-to-back grant, no idle bubble.
    - sel<=W((sel+1)%6), grant<=onehot(new sel), cnt<=0, valid stays 1, ptr<=(new sel+1)%6.
  - Release with req=0: go to IDLE, grant<=0, valid<=0, sel held, ptr<=(sel+1)%6.
- Wrap-around: index 5 is followed by index 0 in every scan.
- Sole requester: if only the current owner requests at timeout, it is re-granted immediately with cnt reset to 0.
- SLOT_LEN=1: release is evaluated true every cycle, so grants rotate every cycle among the active requesters.
- Early drop: req[sel] falling in cycle t ends the grant at edge t+1 regardless of cnt.
- Data gating: out must never expose a non-owner bit.
  - The select logic has a full case with default 0, so no latches.
  - sel values 6 and 7 are unreachable but must decode to out=0.
- grant and sel are always consistent: grant==onehot(sel) whenever valid=1.

Optional Feature:
- Macro: MUX6_ARB_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - While valid=1 and lock=1, the timeout term of release is suppressed, so the owner keeps the channel while req[sel]=1.
  - Dropping req[sel] still releases.
  - lock is ignored in IDLE.
- Undefined:
  - No lock port.
  - Behaviour exactly as above.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=6'b111111 → grant=0, valid=0, sel=0, out=0. Release rst → next cycle grant=000001, sel=0.
- Single requester: req=000100 held 10 cycles, SLOT_LEN=4, a[2] toggling → sel=2 throughout, valid=1, cnt resets every 4 cycles, out tracks a[2] same cycle.
- Rotation: req=100001 held, SLOT_LEN=4 → sel sequence 0,0,0,0,5,5,5,5,0,… with no idle cycle between owners (wrap 5→0 checked).
- Early drop and idle: owner 3 (req=001000), drop req[3] after 2 cycles with req=0 → next cycle valid=0, grant=0. Then req=010000 → grant to 4 (ptr=4) one cycle later.
- Reset mid-grant: rst=1 while sel=5, valid=1 → next edge all outputs at reset values. Restart scanning from index 0 gives sel=0 for req=111111.
- Lock (MUX6_ARB_LOCK_EN defined): owner 1 with lock=1, req=000011 held 12 cycles → sel stays 1. Deassert lock → handover to 0 within SLOT_LEN cycles.
